// File: rtl/rad_mon_pkg.sv
// Shared types and constants for the radiation-monitor readout controller.
package rad_mon_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} rad_mon_ctrl_state_t;

  localparam int C_OVERRUN_WIDTH = 8;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rad_mon_period_timer.sv
// Free-running snapshot period timer; pulses expire_o when the count reaches period-1.
module rad_mon_period_timer #(
  parameter int G_PERIOD_WIDTH = 16
)(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      enable_i,
  input  logic [G_PERIOD_WIDTH-1:0] period_i,
  input  logic                      clear_i,
  output logic                      expire_o
);

  logic [G_PERIOD_WIDTH-1:0] timer_q;
  logic                      run;

  // Compare against the live period so a reprogrammed period applies at the next compare.
  assign run      = enable_i && (period_i != '0);
  assign expire_o = run && (timer_q == period_i - G_PERIOD_WIDTH'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     timer_q <= '0;
    else if (clear_i) timer_q <= '0;
    else if (run)     timer_q <= timer_q + G_PERIOD_WIDTH'(1);
  end

endmodule

// File: rtl/radiation_monitor_readout_ctrl.sv
// Atomic snapshot of channel mismatch counters with clear, streamed out one channel per word.
module radiation_monitor_readout_ctrl
  import rad_mon_pkg::*;
#(
  parameter  int G_NUM_CHANNELS  = 8,
  parameter  int G_COUNTER_WIDTH = 8,
  parameter  int G_PERIOD_WIDTH  = 16,
  localparam int G_IDX_WIDTH     = idx_width(G_NUM_CHANNELS)
)(
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic                                      enable_i,
  input  logic [G_PERIOD_WIDTH-1:0]                 period_i,
  input  logic                                      snapshot_req_i,
  input  logic [G_NUM_CHANNELS*G_COUNTER_WIDTH-1:0] counters_i,
  output logic                                      clear_o,
  output logic                                      data_valid_o,
  input  logic                                      data_ready_i,
  output logic [G_IDX_WIDTH+G_COUNTER_WIDTH-1:0]    data_o,
  output logic                                      data_last_o,
  output logic                                      busy_o,
  output logic [C_OVERRUN_WIDTH-1:0]                overrun_cnt_o
);

  localparam logic [G_IDX_WIDTH-1:0] LAST_IDX = G_IDX_WIDTH'(G_NUM_CHANNELS - 1);

  rad_mon_ctrl_state_t          state_q, state_d;
  logic [G_IDX_WIDTH-1:0]       idx_q;
  logic [G_COUNTER_WIDTH-1:0]   shadow_q [G_NUM_CHANNELS];
  logic [C_OVERRUN_WIDTH-1:0]   overrun_q;
  logic                         expire, trigger, is_idle, is_send, is_last, take;

  assign is_idle = (state_q == IDLE);
  assign is_send = (state_q == SEND);
  assign is_last = is_send && (idx_q == LAST_IDX);
  assign trigger = snapshot_req_i || expire;
  assign take    = is_idle && trigger;

  // Timer only runs in IDLE, so an expiry can never be dropped as an overrun.
  rad_mon_period_timer #(.G_PERIOD_WIDTH(G_PERIOD_WIDTH)) u_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .enable_i (enable_i && is_idle),
    .period_i (period_i),
    .clear_i  (take),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trigger) state_d = CAPTURE;
      CAPTURE: state_d = SEND;
      SEND:    if (data_ready_i && is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q <= '0;
      for (int k = 0; k < G_NUM_CHANNELS; k++) shadow_q[k] <= '0;
    end else if (state_q == CAPTURE) begin
      idx_q <= '0;
      for (int k = 0; k < G_NUM_CHANNELS; k++)
        shadow_q[k] <= counters_i[k*G_COUNTER_WIDTH +: G_COUNTER_WIDTH];
    end else if (is_send && data_ready_i) begin
      idx_q <= is_last ? '0 : idx_q + G_IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      overrun_q <= '0;
    else if (!is_idle && snapshot_req_i && (overrun_q != '1))
      overrun_q <= overrun_q + C_OVERRUN_WIDTH'(1);
  end

  assign clear_o       = (state_q == CAPTURE);
  assign busy_o        = !is_idle;
  assign data_valid_o  = is_send;
  assign data_last_o   = is_last;
  assign data_o        = is_send ? {idx_q, shadow_q[idx_q]} : '0;
  assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_radiation_monitor_readout_ctrl.sv
// Directed scoreboard bench for radiation_monitor_readout_ctrl (N=8, W=8).
module tb_radiation_monitor_readout_ctrl;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int PW = 16;
  localparam int IW = 3;

  typedef struct packed {
    logic [IW+W-1:0] data;
    logic            last;
  } wexp_t;

  logic              clk = 1'b0, rst_n = 1'b0, enable = 1'b0, req = 1'b0, ready = 1'b1;
  logic [PW-1:0]     period = '0;
  logic [N*W-1:0]    counters = '0;
  logic              clear_o, data_valid, data_last, busy;
  logic [IW+W-1:0]   data_o;
  logic [7:0]        overrun;

  radiation_monitor_readout_ctrl #(
    .G_NUM_CHANNELS(N), .G_COUNTER_WIDTH(W), .G_PERIOD_WIDTH(PW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .period_i(period),
    .snapshot_req_i(req), .counters_i(counters), .clear_o(clear_o),
    .data_valid_o(data_valid), .data_ready_i(ready), .data_o(data_o),
    .data_last_o(data_last), .busy_o(busy), .overrun_cnt_o(overrun)
  );

  always #5 clk = ~clk;

  int    total = 0, bad = 0, cyc = 0;
  int    cap_q[$];
  wexp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_stream();
    for (int k = 0; k < N; k++)
      sb.push_back('{data: {IW'(k), counters[k*W +: W]}, last: (k == N-1)});
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clear"}, clear_o, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_last"}, data_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records captures, checks hold-under-backpressure and pops the scoreboard.
  logic            pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [IW+W-1:0] pd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear_o) cap_q.push_back(cyc);
      if (pv && !pr) begin
        chk("hold_valid", data_valid, 1);
        chk("hold_data", data_o, pd);
        chk("hold_last", data_last, pl);
      end
      if (data_valid && ready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_word: observed=%0h expected=none", data_o);
        end
        if (sb.size() != 0) begin
          wexp_t e;
          e = sb.pop_front();
          chk("word_data", data_o, e.data);
          chk("word_last", data_last, e.last);
        end
      end
      pv = data_valid; pr = ready; pd = data_o; pl = data_last;
    end else begin
      pv = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Request only: channel k = k+1, words on consecutive cycles
    for (int k = 0; k < N; k++) counters[k*W +: W] = W'(k + 1);
    push_stream();
    pulse_req();
    @(negedge clk);
    chk("req_clear", clear_o, 1);
    chk("req_busy", busy, 1);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("req_valid", data_valid, 1);
    end
    @(negedge clk);
    chk("req_idle_busy", busy, 0);
    chk("req_idle_valid", data_valid, 0);
    chk("req_sb_empty", sb.size(), 0);

    // Periodic: capture-to-capture = 20 + N + 1
    for (int k = 0; k < N; k++) counters[k*W +: W] = W'(2*k + 9);
    for (int s = 0; s < 6; s++) push_stream();
    base = cap_q.size();
    period = 16'd20;
    @(posedge clk); #1 enable = 1'b1;
    for (int n = 0; n < 400 && cap_q.size() < base + 6; n++) @(posedge clk);
    #1 enable = 1'b0;
    chk("per_caps", cap_q.size() - base, 6);
    for (int i = 1; i < 6; i++)
      if (cap_q.size() > base + i)
        chk("per_interval", cap_q[base+i] - cap_q[base+i-1], 20 + N + 1);
    drain("per_drain", 100);
    chk("per_ovr", overrun, 0);

    // Backpressure with counters changing after capture
    for (int k = 0; k < N; k++) counters[k*W +: W] = W'(8'hA0 + k);
    push_stream();
    period = '0;
    pulse_req();
    @(negedge clk);
    chk("bp_clear", clear_o, 1);
    for (int n = 0; n < 300 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
      ready = 1'($urandom_range(0, 1));
      counters = {$urandom, $urandom};
    end
    chk("bp_sb_empty", sb.size(), 0);
    ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_idle", busy, 0);

    // Simultaneous request and timer expiry (period 5)
    for (int k = 0; k < N; k++) counters[k*W +: W] = W'(8'h40 + 3*k);
    push_stream();
    base = cap_q.size();
    period = 16'd5;
    @(posedge clk); #1 enable = 1'b1;
    repeat (4) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0; enable = 1'b0;
    @(negedge clk);
    chk("sim_clear", clear_o, 1);
    repeat (20) @(posedge clk);
    chk("sim_caps", cap_q.size() - base, 1);
    chk("sim_ovr", overrun, 0);
    chk("sim_sb_empty", sb.size(), 0);

    // Overrun saturation with ready low
    for (int k = 0; k < N; k++) counters[k*W +: W] = W'(8'hF8 + k);
    push_stream();
    period = '0;
    ready = 1'b0;
    @(posedge clk); #1 req = 1'b1;
    repeat (201) @(posedge clk);
    #1 chk("ovr_200", overrun, 200);
    repeat (100) @(posedge clk);
    #1 req = 1'b0;
    chk("ovr_sat", overrun, 255);
    chk("ovr_busy", busy, 1);
    chk("ovr_sb_full", sb.size(), N);
    ready = 1'b1;
    drain("ovr_drain", 50);

    // Reset mid-SEND after 3 words
    for (int k = 0; k < N; k++) counters[k*W +: W] = W'(8'h10 + k);
    for (int k = 0; k < 3; k++)
      sb.push_back('{data: {IW'(k), counters[k*W +: W]}, last: 1'b0});
    pulse_req();
    @(negedge clk);
    chk("rst_clear", clear_o, 1);
    repeat (4) @(posedge clk);
    #1 ready = 1'b0;
    chk("rst_pre_sb", sb.size(), 0);
    chk("rst_pre_valid", data_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    @(posedge clk); #1 rst_n = 1'b1; ready = 1'b1;
    for (int k = 0; k < N; k++) counters[k*W +: W] = W'(8'h70 - k);
    push_stream();
    pulse_req();
    drain("rst_restream", 50);
    @(negedge clk);
    chk("rst_end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/radiation_monitor_readout_ctrl.md
# radiation_monitor_readout_ctrl

Scheduler for a bank of radiation-monitor single-channel mismatch counters. It captures all channel counter values atomically, either on a periodic timer or on software request, and clears the channel counters in the same cycle. It then streams the captured values out one channel per word over a valid/ready handshake. It sits between the TMR mismatch counter bank and the slow-control readout FIFO.

## Interface
- G_NUM_CHANNELS, 8, number of monitored channels (1..64)
- G_COUNTER_WIDTH, 8, width of each channel counter
- G_PERIOD_WIDTH, 16, width of the snapshot period register
- G_IDX_WIDTH, derived = max(1, $clog2(G_NUM_CHANNELS)), channel index width (not overridable)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; asynchronous assert, active-low (fixed)
- enable_i  in  1  enables the periodic timer; requests are honoured regardless
- period_i  in  G_PERIOD_WIDTH  snapshot period in cycles; 0 disables periodic snapshots
- snapshot_req_i  in  1  single-cycle software snapshot request
- counters_i  in  G_NUM_CHANNELS*G_COUNTER_WIDTH  flattened counter values; channel k at bits [k*W +: W]
- clear_o  out  1  one-cycle synchronous clear to all channel counters
- data_valid_o  out  1  output word valid
- data_ready_i  in  1  downstream ready
- data_o  out  G_IDX_WIDTH+G_COUNTER_WIDTH  {channel index, captured count}
- data_last_o  out  1  marks the word for channel G_NUM_CHANNELS-1
- busy_o  out  1  high in CAPTURE and SEND
- overrun_cnt_o  out  8  saturating count of dropped triggers

## Operation
- FSM states: IDLE, CAPTURE, SEND.
- IDLE → CAPTURE when a trigger is sampled. Trigger = snapshot_req_i, or timer expiry.
  - Timer expiry: enable_i=1, period_i≠0, and timer == period_i-1.
  - A simultaneous request and expiry count as one trigger.
- CAPTURE (exactly 1 cycle):
  - latch all of counters_i into the shadow array
  - clear_o=1
  - idx←0, timer←0
  - → SEND
- SEND:
  - data_valid_o=1; data_o={idx, shadow[idx]}; data_last_o=(idx==N-1).
  - On handshake (valid & ready): idx←idx+1. On the last word: → IDLE.
- Timer:
  - counts only in IDLE with enable_i=1 and period_i≠0.
  - holds when enable_i=0.
  - resets to 0 on entering CAPTURE.
  - a period_i change takes effect at the next compare; if the timer already exceeds period_i-1, it wraps at 2^G_PERIOD_WIDTH.
- A trigger occurring in CAPTURE or SEND is dropped; overrun_cnt_o increments, saturating at 255, and is cleared only by reset.
- Events counted by the channels during the CAPTURE cycle are lost to the clear. This is accepted and documented; at most 1 event per channel per snapshot.
- data_o and data_last_o hold stable while data_valid_o=1 and data_ready_i=0.
- Captured values are reported as-is, including saturated values.

## Timing
- Reset (rst_n_i=0, async): state=IDLE, timer=0, idx=0, shadow=0. All outputs are 0: clear_o, data_valid_o, data_o, data_last_o, busy_o, overrun_cnt_o.
- Reset release is synchronised externally; the block only requires a deassertion that is synchronous to clk_i.
- All outputs are registered or decoded directly from registered state; there is no combinational path from data_ready_i to any output.
- Trigger sampled at edge t:
  - CAPTURE during cycle t+1; clear_o=1 and busy_o=1 in that cycle.
  - First data_valid_o=1 in cycle t+2.
- With data_ready_i held at 1, one word per cycle: the last word is in cycle t+1+N, and IDLE is reached in cycle t+2+N.
- Minimum snapshot-to-snapshot interval: N+2 cycles.
- Reset during SEND aborts the stream immediately. A partial stream carries no data_last_o; downstream must tolerate this.

## Structure
- Shared package rad_mon_pkg:
  - state enum rad_mon_ctrl_state_t {IDLE, CAPTURE, SEND}
  - overrun counter width constant C_OVERRUN_WIDTH=8
  - function for the index width
- Sub-module rad_mon_period_timer: counter plus compare, producing the expiry pulse. Inputs: enable, period, clear.
- Shadow array: a flip-flop array, not BRAM; indexed by an output mux.

## Test plan
- Request only: N=8, period_i=0, counters_i channel k = k+1, pulse snapshot_req_i, ready=1.
  - clear_o one cycle after the request.
  - Words {0,1}..{7,8} on consecutive cycles; data_last_o only with {7,8}.
- Periodic: period_i=20, enable_i=1, no requests.
  - CAPTURE exactly every 20+(N+1) cycles measured from capture to capture. Over 200 cycles: 6 streams, overrun_cnt_o=0.
- Backpressure: data_ready_i toggled randomly per cycle during SEND.
  - Each word held stable until accepted; no index skipped or repeated; counters_i changes after CAPTURE do not alter the streamed data.
- Overrun: 300 requests issued while busy, ready=0.
  - overrun_cnt_o saturates at 255; the stream in progress is unaffected.
- Simultaneous request and timer expiry in the same cycle:
  - exactly one CAPTURE; overrun_cnt_o unchanged.
- Reset mid-SEND after 3 words:
  - all outputs 0 asynchronously; after release, a new request yields a full N-word stream starting at index 0.
